// File: rtl/axi_wr_arbiter.sv
// Two-requester AXI write arbiter: 1-cycle registered grant, then AW/W/B forwarded combinationally from the owner.
// Backpressure: owner readies mirror the shared port in the active phase only; non-owner and off-phase traffic stalls.
`timescale 1ns/1ps
module axi_wr_arbiter #(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic            axi_aclk,
  input  logic            axi_aresetn,
  input  logic [AW-1:0]   m0_awaddr,
  input  logic [7:0]      m0_awlen,
  input  logic [2:0]      m0_awsize,
  input  logic [1:0]      m0_awburst,
  input  logic            m0_awvalid,
  output logic            m0_awready,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_wstrb,
  input  logic            m0_wlast,
  input  logic            m0_wvalid,
  output logic            m0_wready,
  output logic [1:0]      m0_bresp,
  output logic            m0_bvalid,
  input  logic            m0_bready,
  input  logic [AW-1:0]   m1_awaddr,
  input  logic [7:0]      m1_awlen,
  input  logic [2:0]      m1_awsize,
  input  logic [1:0]      m1_awburst,
  input  logic            m1_awvalid,
  output logic            m1_awready,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wstrb,
  input  logic            m1_wlast,
  input  logic            m1_wvalid,
  output logic            m1_wready,
  output logic [1:0]      m1_bresp,
  output logic            m1_bvalid,
  input  logic            m1_bready,
  output logic [AW-1:0]   axi_awaddr,
  output logic [7:0]      axi_awlen,
  output logic [2:0]      axi_awsize,
  output logic [1:0]      axi_awburst,
  output logic            axi_awvalid,
  input  logic            axi_awready,
  output logic [DW-1:0]   axi_wdata,
  output logic [DW/8-1:0] axi_wstrb,
  output logic            axi_wlast,
  output logic            axi_wvalid,
  input  logic            axi_wready,
  input  logic [1:0]      axi_bresp,
  input  logic            axi_bvalid,
  output logic            axi_bready,
  output logic [1:0]      gnt,
  output logic            wlast_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t     state;
  logic       own;       // 0 = m0 owns, 1 = m1 owns; meaningful outside IDLE
  logic       rr;        // requester favoured on a tie
  logic [7:0] len_q;
  logic [7:0] beat_cnt;
  logic       pick;
  logic       own_wlast;

  assign pick      = (m0_awvalid && m1_awvalid) ? rr : m1_awvalid;
  assign own_wlast = own ? m1_wlast : m0_wlast;

  always_comb begin
    axi_awaddr  = own ? m1_awaddr  : m0_awaddr;
    axi_awlen   = own ? m1_awlen   : m0_awlen;
    axi_awsize  = own ? m1_awsize  : m0_awsize;
    axi_awburst = own ? m1_awburst : m0_awburst;
    axi_awvalid = (state == ADDR) && (own ? m1_awvalid : m0_awvalid);
    axi_wdata   = own ? m1_wdata : m0_wdata;
    axi_wstrb   = own ? m1_wstrb : m0_wstrb;
    axi_wvalid  = (state == DATA) && (own ? m1_wvalid : m0_wvalid);
    axi_wlast   = (state == DATA) && (beat_cnt == len_q);
    axi_bready  = (state == RESP) && (own ? m1_bready : m0_bready);
    m0_awready  = (state == ADDR) && !own && axi_awready;
    m1_awready  = (state == ADDR) &&  own && axi_awready;
    m0_wready   = (state == DATA) && !own && axi_wready;
    m1_wready   = (state == DATA) &&  own && axi_wready;
    m0_bvalid   = (state == RESP) && !own && axi_bvalid;
    m1_bvalid   = (state == RESP) &&  own && axi_bvalid;
    m0_bresp    = ((state == RESP) && !own) ? axi_bresp : 2'b00;
    m1_bresp    = ((state == RESP) &&  own) ? axi_bresp : 2'b00;
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state     <= IDLE;
      gnt       <= 2'b00;
      own       <= 1'b0;
      rr        <= 1'b0;
      len_q     <= 8'd0;
      beat_cnt  <= 8'd0;
      wlast_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_awvalid || m1_awvalid) begin
            own   <= pick;
            gnt   <= pick ? 2'b10 : 2'b01;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (axi_awvalid && axi_awready) begin
            len_q    <= axi_awlen;
            beat_cnt <= 8'd0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (axi_wvalid && axi_wready) begin
            // Requester wlast is only audited; the generated one always governs the burst.
            if (own_wlast != axi_wlast) wlast_err <= 1'b1;
            beat_cnt <= beat_cnt + 8'd1;
            if (axi_wlast) state <= RESP;
          end
        end
        RESP: begin
          if (axi_bvalid && axi_bready) begin
            rr    <= ~own;
            gnt   <= 2'b00;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: random and directed write bursts from two requesters,
// transaction-level model predicts grant order, beats, generated wlast and the sticky error.
`timescale 1ns/1ps
module tb_axi_wr_arbiter;

  localparam int LIMIT = 4000;

  typedef struct packed {
    logic        id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [63:0] base;
    logic [7:0]  strb;
    logic        bad;
  } txn_t;

  logic        axi_aclk;
  logic        axi_aresetn;
  logic [31:0] m_awaddr  [2];
  logic [7:0]  m_awlen   [2];
  logic [2:0]  m_awsize  [2];
  logic [1:0]  m_awburst [2];
  logic        m_awvalid [2];
  logic        m_awready [2];
  logic [63:0] m_wdata   [2];
  logic [7:0]  m_wstrb   [2];
  logic        m_wlast   [2];
  logic        m_wvalid  [2];
  logic        m_wready  [2];
  logic [1:0]  m_bresp   [2];
  logic        m_bvalid  [2];
  logic        m_bready  [2];
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_awvalid, axi_awready;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_wlast, axi_wvalid, axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid, axi_bready;
  logic [1:0]  gnt;
  logic        wlast_err;

  int   tests = 0;
  int   fails = 0;
  txn_t exp_q[$];
  txn_t cur;
  logic cur_vld = 1'b0;
  int   beat = 0;
  logic err_exp = 1'b0;
  logic rr_m = 1'b0;
  logic slave_rnd = 1'b0;

  axi_wr_arbiter #(.AW(32), .DW(64)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .m0_awaddr(m_awaddr[0]), .m0_awlen(m_awlen[0]), .m0_awsize(m_awsize[0]), .m0_awburst(m_awburst[0]),
    .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]),
    .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wlast(m_wlast[0]),
    .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]),
    .m0_bresp(m_bresp[0]), .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]),
    .m1_awaddr(m_awaddr[1]), .m1_awlen(m_awlen[1]), .m1_awsize(m_awsize[1]), .m1_awburst(m_awburst[1]),
    .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]),
    .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wlast(m_wlast[1]),
    .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]),
    .m1_bresp(m_bresp[1]), .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .gnt(gnt), .wlast_err(wlast_err)
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic flag(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: event outside expected sequence or bound expired", nm);
  endtask

  function automatic logic [63:0] wd(input logic [63:0] b, input int i);
    return b + 64'(i) * 64'h0101_0101_0101_0101;
  endfunction

  function automatic txn_t mk(input logic id, input int len, input logic bad);
    txn_t t;
    t.id    = id;
    t.addr  = $urandom;
    t.len   = 8'(len);
    t.size  = 3'($urandom);
    t.burst = 2'($urandom);
    t.base  = {$urandom, $urandom};
    t.strb  = 8'($urandom);
    t.bad   = bad;
    return t;
  endfunction

  // Downstream slave and requester bready: always ready, or randomly stalling.
  always @(posedge axi_aclk) begin
    #1;
    axi_awready = slave_rnd ? 1'($urandom % 2) : 1'b1;
    axi_wready  = slave_rnd ? ($urandom % 4 != 0) : 1'b1;
    axi_bvalid  = slave_rnd ? 1'($urandom % 2) : 1'b1;
    axi_bresp   = slave_rnd ? 2'($urandom) : 2'b00;
    for (int n = 0; n < 2; n++) m_bready[n] = slave_rnd ? 1'($urandom % 2) : 1'b1;
  end

  // Monitor / scoreboard.
  always @(negedge axi_aclk) begin
    if (!axi_aresetn) begin
      exp_q.delete();
      cur_vld = 1'b0;
      err_exp = 1'b0;
    end else begin
      chk("gnt_legal", 64'(gnt == 2'b11), 64'd0);
      for (int n = 0; n < 2; n++) begin
        if (!gnt[n]) begin
          chk("nonowner_awready", 64'(m_awready[n]), 64'd0);
          chk("nonowner_wready", 64'(m_wready[n]), 64'd0);
          chk("nonowner_bvalid", 64'(m_bvalid[n]), 64'd0);
        end
      end
      chk("wlast_err", 64'(wlast_err), 64'(err_exp));
      if (axi_awvalid && axi_awready) begin
        if (cur_vld || exp_q.size() == 0) flag("aw_unexpected");
        else begin
          cur = exp_q.pop_front();
          cur_vld = 1'b1;
          beat = 0;
          chk("aw_gnt", 64'(gnt), cur.id ? 64'd2 : 64'd1);
          chk("awaddr", 64'(axi_awaddr), 64'(cur.addr));
          chk("awlen", 64'(axi_awlen), 64'(cur.len));
          chk("awsize", 64'(axi_awsize), 64'(cur.size));
          chk("awburst", 64'(axi_awburst), 64'(cur.burst));
        end
      end
      if (axi_wvalid && axi_wready) begin
        if (!cur_vld) flag("w_unexpected");
        else begin
          logic ew;
          ew = (beat == int'(cur.len));
          chk("wdata", axi_wdata, wd(cur.base, beat));
          chk("wstrb", 64'(axi_wstrb), 64'(cur.strb));
          chk("axi_wlast", 64'(axi_wlast), 64'(ew));
          if (m_wlast[cur.id] != ew) err_exp = 1'b1;
          beat++;
        end
      end
      for (int n = 0; n < 2; n++) begin
        if (m_bvalid[n] && m_bready[n]) begin
          if (!cur_vld) flag("b_unexpected");
          else begin
            chk("b_id", 64'(n), 64'(cur.id));
            chk("b_beats", 64'(beat), 64'(cur.len) + 64'd1);
            chk("bresp", 64'(m_bresp[n]), 64'(axi_bresp));
            chk("axi_bready", 64'(axi_bready), 64'd1);
            cur_vld = 1'b0;
          end
        end
      end
    end
  end

  task automatic drive(input txn_t t);
    int n;
    n = int'(t.id);
    fork
      begin : aw_ch
        int w;
        m_awaddr[n] = t.addr; m_awlen[n] = t.len; m_awsize[n] = t.size; m_awburst[n] = t.burst;
        m_awvalid[n] = 1'b1;
        w = 0;
        forever begin
          @(negedge axi_aclk);
          if (m_awready[n]) break;
          if (++w > LIMIT) begin flag("aw_timeout"); break; end
        end
        @(posedge axi_aclk); #1;
        m_awvalid[n] = 1'b0;
      end
      begin : w_ch
        for (int i = 0; i <= int'(t.len); i++) begin
          int w;
          if (slave_rnd && ($urandom % 3 == 0)) begin
            m_wvalid[n] = 1'b0;
            @(posedge axi_aclk); #1;
          end
          m_wdata[n]  = wd(t.base, i);
          m_wstrb[n]  = t.strb;
          m_wlast[n]  = (t.bad && i == 0) ? 1'b1 : (i == int'(t.len));
          m_wvalid[n] = 1'b1;
          w = 0;
          forever begin
            @(negedge axi_aclk);
            if (m_wready[n]) break;
            if (++w > LIMIT) begin flag("w_timeout"); break; end
          end
          @(posedge axi_aclk); #1;
        end
        m_wvalid[n] = 1'b0;
        m_wlast[n]  = 1'b0;
      end
    join
    begin
      int w;
      w = 0;
      forever begin
        @(negedge axi_aclk);
        if (m_bvalid[n] && m_bready[n]) break;
        if (++w > LIMIT) begin flag("b_timeout"); break; end
      end
      @(posedge axi_aclk); #1;
    end
  endtask

  // mode 0: m0 alone, 1: m1 alone, 2: both at once. Model: a tie goes to rr_m, which
  // afterwards points away from whoever completed last.
  task automatic run_round(input int mode, input int lo, input int hi, input logic bad);
    txn_t a, b;
    a = mk(1'b0, $urandom_range(hi, lo), bad);
    b = mk(1'b1, $urandom_range(hi, lo), 1'b0);
    if (mode == 0) begin
      exp_q.push_back(a); rr_m = 1'b1;
      drive(a);
    end else if (mode == 1) begin
      exp_q.push_back(b); rr_m = 1'b0;
      drive(b);
    end else begin
      if (rr_m == 1'b0) begin exp_q.push_back(a); exp_q.push_back(b); end
      else begin exp_q.push_back(b); exp_q.push_back(a); end
      fork
        drive(a);
        drive(b);
      join
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    int   w;
    axi_aresetn = 1'b0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
    for (int n = 0; n < 2; n++) begin
      m_awaddr[n] = '0; m_awlen[n] = '0; m_awsize[n] = '0; m_awburst[n] = '0; m_awvalid[n] = 1'b0;
      m_wdata[n] = '0; m_wstrb[n] = '0; m_wlast[n] = 1'b0; m_wvalid[n] = 1'b0; m_bready[n] = 1'b0;
    end
    repeat (3) @(posedge axi_aclk);
    @(negedge axi_aclk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_awvalid", 64'(axi_awvalid), 64'd0);
    chk("rst_wvalid", 64'(axi_wvalid), 64'd0);
    chk("rst_bready", 64'(axi_bready), 64'd0);
    chk("rst_wlast_err", 64'(wlast_err), 64'd0);
    chk("rst_m0_awready", 64'(m_awready[0]), 64'd0);
    chk("rst_m1_bvalid", 64'(m_bvalid[1]), 64'd0);
    @(posedge axi_aclk); #1;
    axi_aresetn = 1'b1;
    @(posedge axi_aclk); #1;

    // Simultaneous single-beat requests twice: m0, m1, m0, m1.
    run_round(2, 0, 0, 1'b0);
    run_round(2, 0, 0, 1'b0);

    // m0 alone, 4 beats, fully ready slave; grant appears one cycle after the request.
    t = mk(1'b0, 3, 1'b0);
    exp_q.push_back(t); rr_m = 1'b1;
    fork
      drive(t);
      begin
        @(negedge axi_aclk); chk("gnt_before_edge", 64'(gnt), 64'd0);
        @(negedge axi_aclk); chk("gnt_after_edge", 64'(gnt), 64'd1);
      end
    join
    @(negedge axi_aclk); chk("gnt_released", 64'(gnt), 64'd0);
    @(posedge axi_aclk); #1;

    // m1 holds wvalid with foreign data while m0 owns the bus.
    m_wdata[1] = 64'hBAD0_BAD0_BAD0_BAD0; m_wvalid[1] = 1'b1;
    run_round(0, 2, 5, 1'b0);
    m_wvalid[1] = 1'b0;

    // Long burst with random stalls.
    slave_rnd = 1'b1;
    run_round(1, 255, 255, 1'b0);
    chk("long_burst_wlast_err", 64'(wlast_err), 64'd0);

    for (int r = 0; r < 40; r++) run_round($urandom_range(2, 0), 0, 15, 1'b0);

    // Early requester wlast on a 2-beat burst; error is sticky.
    run_round(0, 1, 1, 1'b1);
    chk("wlast_err_set", 64'(wlast_err), 64'd1);
    run_round(0, 0, 4, 1'b0);
    chk("wlast_err_sticky", 64'(wlast_err), 64'd1);

    // Reset in the middle of beat 2 of a 4-beat m0 burst (rr currently favours m1).
    slave_rnd = 1'b0;
    @(posedge axi_aclk); #1;
    t = mk(1'b0, 3, 1'b0);
    exp_q.push_back(t);
    m_awaddr[0] = t.addr; m_awlen[0] = t.len; m_awsize[0] = t.size; m_awburst[0] = t.burst;
    m_awvalid[0] = 1'b1;
    w = 0;
    do begin @(negedge axi_aclk); w++; end while (!m_awready[0] && w < LIMIT);
    if (w >= LIMIT) flag("rst_aw_timeout");
    @(posedge axi_aclk); #1;
    m_awvalid[0] = 1'b0;
    m_wdata[0] = wd(t.base, 0); m_wstrb[0] = t.strb; m_wlast[0] = 1'b0; m_wvalid[0] = 1'b1;
    w = 0;
    do begin @(negedge axi_aclk); w++; end while (!m_wready[0] && w < LIMIT);
    if (w >= LIMIT) flag("rst_w_timeout");
    @(posedge axi_aclk); #1;
    m_wdata[0] = wd(t.base, 1);
    axi_aresetn = 1'b0;
    @(posedge axi_aclk); #1;
    @(negedge axi_aclk);
    chk("midrst_awvalid", 64'(axi_awvalid), 64'd0);
    chk("midrst_wvalid", 64'(axi_wvalid), 64'd0);
    chk("midrst_bready", 64'(axi_bready), 64'd0);
    chk("midrst_gnt", 64'(gnt), 64'd0);
    chk("midrst_m0_wready", 64'(m_wready[0]), 64'd0);
    chk("midrst_wlast_err", 64'(wlast_err), 64'd0);
    m_wvalid[0] = 1'b0;
    @(posedge axi_aclk); #1;
    axi_aresetn = 1'b1;
    rr_m = 1'b0;
    @(posedge axi_aclk); #1;
    run_round(2, 0, 3, 1'b0);

    repeat (3) @(posedge axi_aclk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("no_open_txn", 64'(cur_vld), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_wr_arbiter.md
AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 64, write data width; strobe width is DW/8.
REQ-003 axi_aclk  input  1  single clock; all logic on its rising edge.
REQ-004 axi_aresetn  input  1  reset, synchronous, active-low.
REQ-005 mN_awaddr/mN_awlen/mN_awsize/mN_awburst (N=0,1)  input  AW/8/3/2  requester N write-address payload.
REQ-006 mN_awvalid  input  1 / mN_awready  output  1  requester N AW handshake.
REQ-007 mN_wdata/mN_wstrb/mN_wlast  input  DW/DW8/1  requester N write-data payload.
REQ-008 mN_wvalid  input  1 / mN_wready  output  1  requester N W handshake.
REQ-009 mN_bresp  output  2 / mN_bvalid  output  1 / mN_bready  input  1  requester N B channel.
REQ-010 axi_awaddr/axi_awlen/axi_awsize/axi_awburst/axi_awvalid  output  AW/8/3/2/1; axi_awready  input  1  shared AW port.
REQ-011 axi_wdata/axi_wstrb/axi_wlast/axi_wvalid  output  DW/DW8/1/1; axi_wready  input  1  shared W port.
REQ-012 axi_bresp  input  2 / axi_bvalid  input  1 / axi_bready  output  1  shared B port.
REQ-013 gnt  output  2  one-hot current owner, 2'b00 when idle.
REQ-014 wlast_err  output  1  sticky flag: requester wlast disagreed with generated wlast.

Function
REQ-015 FSM states SHALL be IDLE, ADDR, DATA, RESP; exactly one transaction owner from ADDR through RESP.
REQ-016 IDLE: if exactly one mN_awvalid is high, that N is granted; if both, grant the requester not granted last (rr pointer); next state ADDR, gnt registered (1-cycle grant latency).
REQ-017 rr pointer SHALL flip to the other requester on each B handshake; after reset m0 has priority.
REQ-018 ADDR: axi_aw* = owner's aw payload and awvalid combinationally; owner awready = axi_awready; on axi_awvalid&&axi_awready latch awlen into len_q, clear beat counter, go DATA.
REQ-019 DATA: axi_wdata/axi_wstrb/axi_wvalid = owner's; owner wready = axi_wready; axi_wlast = (beat_cnt == len_q), generated internally, never passed through.
REQ-020 Each W handshake in DATA SHALL increment the 8-bit beat_cnt; the handshake with axi_wlast=1 moves to RESP; awlen=0 means a single beat; awlen=255 means 256 beats with no counter wrap before last.
REQ-021 On a W handshake where owner mN_wlast != axi_wlast, wlast_err SHALL set and stay set until reset; the transfer is still forwarded and beat counting is unchanged.
REQ-022 RESP: owner bvalid = axi_bvalid, owner bresp = axi_bresp, axi_bready = owner bready; on B handshake go IDLE, gnt=00.
REQ-023 Non-owner requesters SHALL see awready=0, wready=0, bvalid=0 at all times; owner sees awready=0 outside ADDR, wready=0 outside DATA, bvalid=0 outside RESP.
REQ-024 Shared-port valids SHALL be 0 in IDLE; axi_awvalid only in ADDR, axi_wvalid only in DATA, axi_bready only in RESP; data presented early by the owner (W before AW) is held off, not dropped.
REQ-025 A new request arriving in RESP SHALL be arbitrated only in the following IDLE cycle (one dead cycle between transactions).
REQ-026 Requests withdrawn in IDLE before grant are ignored; once granted, ADDR waits indefinitely for the owner's awvalid.

Reset
REQ-027 While axi_aresetn=0 at a clock edge: state=IDLE, gnt=00, rr priority=m0, beat_cnt=0, len_q=0, wlast_err=0, all valid/ready outputs 0.
REQ-028 Reset asserted mid-transaction SHALL abandon it immediately (no completion of beats or response) and obey REQ-027 on the next edge.

Verification
REQ-029 m0 awvalid, awlen=3, axi_awready/wready/bvalid always 1 -> gnt=01 one cycle later, 4 W beats, axi_wlast only on beat 4, m0_bvalid pulse, gnt=00.
REQ-030 m0 and m1 request simultaneously, both awlen=0, twice -> grant order m0, m1, m0, m1; no overlapping gnt.
REQ-031 m1 awlen=255 with random axi_wready stalls -> exactly 256 W handshakes, axi_wlast on 256th only, wlast_err stays 0.
REQ-032 m0 awlen=1 but drives wlast=1 on beat 1 -> wlast_err=1 after beat 1, transfer still completes after beat 2, error persists until reset.
REQ-033 m0 owner, m1 wvalid=1 throughout -> m1_wready stays 0 and no m1 data appears on axi_wdata.
REQ-034 Reset asserted during DATA beat 2 of 4 -> next cycle all shared valids 0, gnt=00, m0 wins a subsequent simultaneous request.
